// File: rtl/decode_pkg.sv
// Shared definitions for the ARM decode stage: instruction classes, field
// positions, the NOP encoding and data-processing opcodes.
package decode_pkg;

  typedef enum logic [1:0] {
    CLS_DP    = 2'b00,
    CLS_LS    = 2'b01,
    CLS_BR    = 2'b10,
    CLS_UNDEF = 2'b11
  } cls_e;

  localparam int COND_HI    = 31;
  localparam int COND_LO    = 28;
  localparam int CLS_HI     = 27;
  localparam int CLS_LO     = 26;
  localparam int IMM_BIT    = 25;
  localparam int OPC_HI     = 24;
  localparam int OPC_LO     = 21;
  localparam int S_BIT      = 20;
  localparam int RN_HI      = 19;
  localparam int RN_LO      = 16;
  localparam int RD_HI      = 15;
  localparam int RD_LO      = 12;
  localparam int RS_HI      = 11;
  localparam int RS_LO      = 8;
  localparam int RS_REG_BIT = 4;
  localparam int RM_HI      = 3;
  localparam int RM_LO      = 0;

  // MOV r0,r0
  localparam logic [31:0] NOP = 32'hE1A0_0000;

  localparam logic [3:0] OPC_TST = 4'b1000;
  localparam logic [3:0] OPC_TEQ = 4'b1001;
  localparam logic [3:0] OPC_CMP = 4'b1010;
  localparam logic [3:0] OPC_CMN = 4'b1011;
  localparam logic [3:0] OPC_MOV = 4'b1101;
  localparam logic [3:0] OPC_MVN = 4'b1111;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode handshake: instruction, PC and the decode stage's ready.
interface decode_stage_if #(
  parameter int N = 32
);
  logic         if_valid;
  logic [N-1:0] if_instr;
  logic [N-1:0] if_pc;
  logic         if_ready;

  modport master (output if_valid, if_instr, if_pc, input if_ready);
  modport slave  (input if_valid, if_instr, if_pc, output if_ready);
endinterface

// File: rtl/decode_fields.sv
// Purely combinational field decode of a held ARM instruction: class,
// source-operand usage, write-back enable and the extended immediate.
module decode_fields
  import decode_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] instr,
  output logic [3:0]   cond,
  output cls_e         cls,
  output logic         uses_rn,
  output logic         uses_rm,
  output logic         uses_rs,
  output logic         uses_rd_src,
  output logic         wb_en,
  output logic [N-1:0] imm
);

  logic [3:0] opc;
  logic       is_dp;
  logic       is_ls;
  logic       reg_op;

  always_comb begin
    cond   = instr[COND_HI:COND_LO];
    cls    = cls_e'(instr[CLS_HI:CLS_LO]);
    opc    = instr[OPC_HI:OPC_LO];
    is_dp  = (cls == CLS_DP);
    is_ls  = (cls == CLS_LS);
    reg_op = ~instr[IMM_BIT];

    uses_rn     = (is_dp && !(opc inside {OPC_MOV, OPC_MVN})) || is_ls;
    uses_rm     = (is_dp || is_ls) && reg_op;
    uses_rs     = is_dp && reg_op && instr[RS_REG_BIT];
    uses_rd_src = is_ls && !instr[S_BIT];

    wb_en = (is_dp && !(opc inside {OPC_TST, OPC_TEQ, OPC_CMP, OPC_CMN}))
            || (is_ls && instr[S_BIT]);

    imm = '0;
    unique case (cls)
      CLS_DP:    imm = N'(instr[7:0]);
      CLS_LS:    imm = N'(instr[11:0]);
      CLS_BR:    imm = {{(N-26){instr[23]}}, instr[23:0], 2'b00};
      CLS_UNDEF: imm = '0;
      default:   imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// IF/ID pipeline register with ARM field decode, load-use hazard detection
// against execute, bubble insertion and a saturating stall counter.
module decode_stage
  import decode_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  decode_stage_if.slave     fetch,
  input  logic              flush,
  input  logic              stall_in,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic [3:0]        ex_rd,
  output logic [3:0]        rf_addr1,
  output logic [3:0]        rf_addr2,
  output logic [3:0]        rf_addr3,
  output logic [3:0]        rf_addr4,
  output logic              id_valid,
  output logic [N-1:0]      id_pc,
  output logic [3:0]        id_cond,
  output logic [1:0]        id_class,
  output logic              id_imm_en,
  output logic              id_set_flags,
  output logic              id_is_load,
  output logic              id_wb_en,
  output logic [3:0]        id_rd,
  output logic [N-1:0]      id_imm,
  output logic              id_illegal,
  output logic [CNT_W-1:0]  stall_count
);

  logic         valid_q;
  logic [N-1:0] instr_q;
  logic [N-1:0] pc_q;
  cls_e         cls;
  logic         uses_rn, uses_rm, uses_rs, uses_rd_src;
  logic         src_match;
  logic         hazard;
  logic         hold;

  decode_fields #(.N(N)) u_fields (
    .instr       (instr_q),
    .cond        (id_cond),
    .cls         (cls),
    .uses_rn     (uses_rn),
    .uses_rm     (uses_rm),
    .uses_rs     (uses_rs),
    .uses_rd_src (uses_rd_src),
    .wb_en       (id_wb_en),
    .imm         (id_imm)
  );

  always_comb begin
    rf_addr1 = instr_q[RN_HI:RN_LO];
    rf_addr2 = instr_q[RM_HI:RM_LO];
    rf_addr3 = instr_q[RS_HI:RS_LO];
    rf_addr4 = instr_q[RD_HI:RD_LO];

    src_match = (uses_rn     && (ex_rd == rf_addr1)) ||
                (uses_rm     && (ex_rd == rf_addr2)) ||
                (uses_rs     && (ex_rd == rf_addr3)) ||
                (uses_rd_src && (ex_rd == rf_addr4));
    hazard = valid_q && ex_valid && ex_is_load && src_match;
    hold   = stall_in || hazard;

    // ready reflects hold only; a flushed cycle still reports ready while
    // dropping whatever fetch offers.
    fetch.if_ready = ~hold;
    id_valid       = valid_q && !hazard && !flush;

    id_pc        = pc_q;
    id_class     = cls;
    id_imm_en    = instr_q[IMM_BIT];
    id_set_flags = (cls == CLS_DP) && instr_q[S_BIT];
    id_is_load   = (cls == CLS_LS) && instr_q[S_BIT];
    id_rd        = instr_q[RD_HI:RD_LO];
    id_illegal   = (cls == CLS_UNDEF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= N'(NOP);
      pc_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      instr_q <= N'(NOP);
    end else if (hold) begin
      valid_q <= valid_q;
    end else if (fetch.if_valid) begin
      valid_q <= 1'b1;
      instr_q <= fetch.if_instr;
      pc_q    <= fetch.if_pc;
    end else begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_count <= '0;
    else if (hazard && (stall_count != '1))
      stall_count <= stall_count + 1'b1;
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode fields, load-use bubbles, holds,
// flush priority, counter saturation and reset during a hazard.
module tb_decode_stage;

  localparam int N     = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush, stall_in, ex_valid, ex_is_load;
  logic [3:0]       ex_rd;
  logic [3:0]       rf_addr1, rf_addr2, rf_addr3, rf_addr4;
  logic             id_valid;
  logic [N-1:0]     id_pc;
  logic [3:0]       id_cond;
  logic [1:0]       id_class;
  logic             id_imm_en, id_set_flags, id_is_load, id_wb_en;
  logic [3:0]       id_rd;
  logic [N-1:0]     id_imm;
  logic             id_illegal;
  logic [CNT_W-1:0] stall_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  decode_stage_if #(.N(N)) fetch_bus ();

  decode_stage #(.N(N), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch        (fetch_bus.slave),
    .flush        (flush),
    .stall_in     (stall_in),
    .ex_valid     (ex_valid),
    .ex_is_load   (ex_is_load),
    .ex_rd        (ex_rd),
    .rf_addr1     (rf_addr1),
    .rf_addr2     (rf_addr2),
    .rf_addr3     (rf_addr3),
    .rf_addr4     (rf_addr4),
    .id_valid     (id_valid),
    .id_pc        (id_pc),
    .id_cond      (id_cond),
    .id_class     (id_class),
    .id_imm_en    (id_imm_en),
    .id_set_flags (id_set_flags),
    .id_is_load   (id_is_load),
    .id_wb_en     (id_wb_en),
    .id_rd        (id_rd),
    .id_imm       (id_imm),
    .id_illegal   (id_illegal),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    fetch_bus.if_valid = 1'b1;
    fetch_bus.if_instr = instr;
    fetch_bus.if_pc    = pc;
    step();
    fetch_bus.if_valid = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall_in = 1'b0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 4'd0;
    fetch_bus.if_valid = 1'b0;
    fetch_bus.if_instr = '0;
    fetch_bus.if_pc    = '0;
    step(); step();
    rst = 1'b0;
    step();

    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_if_ready", 32'(fetch_bus.if_ready), 32'd1);
    chk("rst_rf_addr1", 32'(rf_addr1), 32'd0);
    chk("rst_rf_addr2", 32'(rf_addr2), 32'd0);
    chk("rst_rf_addr3", 32'(rf_addr3), 32'd0);
    chk("rst_rf_addr4", 32'(rf_addr4), 32'd0);
    chk("rst_stall_count", 32'(stall_count), 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_cond", 32'(id_cond), 32'hE);

    // ADD r1,r2,r3
    issue(32'hE082_1003, 32'h100);
    chk("add_id_valid", 32'(id_valid), 32'd1);
    chk("add_rf_addr1", 32'(rf_addr1), 32'd2);
    chk("add_rf_addr2", 32'(rf_addr2), 32'd3);
    chk("add_rf_addr3", 32'(rf_addr3), 32'd0);
    chk("add_id_rd", 32'(id_rd), 32'd1);
    chk("add_wb_en", 32'(id_wb_en), 32'd1);
    chk("add_class", 32'(id_class), 32'd0);
    chk("add_pc", id_pc, 32'h100);
    chk("add_imm", id_imm, 32'h3);
    chk("add_set_flags", 32'(id_set_flags), 32'd0);

    ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = 4'd3; #1;
    chk("nohaz_not_load", 32'(id_valid), 32'd1);
    ex_is_load = 1'b1; ex_rd = 4'd1; #1;
    chk("nohaz_rd_not_src", 32'(id_valid), 32'd1);
    ex_rd = 4'd3; #1;
    chk("haz_id_valid", 32'(id_valid), 32'd0);
    chk("haz_if_ready", 32'(fetch_bus.if_ready), 32'd0);
    chk("haz_count_pre", 32'(stall_count), 32'd0);
    step();
    ex_valid = 1'b0; #1;
    chk("haz_count", 32'(stall_count), 32'd1);
    chk("haz_release_valid", 32'(id_valid), 32'd1);
    chk("haz_release_ready", 32'(fetch_bus.if_ready), 32'd1);
    chk("haz_retained_rm", 32'(rf_addr2), 32'd3);
    chk("haz_retained_pc", id_pc, 32'h100);

    // Downstream stall while a branch is offered
    stall_in = 1'b1;
    fetch_bus.if_valid = 1'b1;
    fetch_bus.if_instr = 32'hEAFF_FFFE;
    fetch_bus.if_pc    = 32'h200;
    #1;
    chk("stall_if_ready", 32'(fetch_bus.if_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_held_rn", 32'(rf_addr1), 32'd2);
      chk("stall_held_pc", id_pc, 32'h100);
      chk("stall_if_ready_cyc", 32'(fetch_bus.if_ready), 32'd0);
      chk("stall_count_same", 32'(stall_count), 32'd1);
    end
    stall_in = 1'b0;
    step();
    fetch_bus.if_valid = 1'b0; #1;
    chk("br_class", 32'(id_class), 32'd2);
    chk("br_imm", id_imm, 32'hFFFF_FFF8);
    chk("br_wb_en", 32'(id_wb_en), 32'd0);
    chk("br_pc", id_pc, 32'h200);
    chk("br_valid", 32'(id_valid), 32'd1);

    // LDR r4,[r5,...] register form with Rm=8
    issue(32'hE595_4008, 32'h204);
    chk("ldr_class", 32'(id_class), 32'd1);
    chk("ldr_is_load", 32'(id_is_load), 32'd1);
    chk("ldr_wb_en", 32'(id_wb_en), 32'd1);
    chk("ldr_imm", id_imm, 32'h008);
    chk("ldr_set_flags", 32'(id_set_flags), 32'd0);
    chk("ldr_rf_addr4", 32'(rf_addr4), 32'd4);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 4'd4; #1;
    chk("ldr_rd_not_src", 32'(id_valid), 32'd1);
    ex_rd = 4'd8; #1;
    chk("ldr_rm_haz", 32'(id_valid), 32'd0);
    ex_valid = 1'b0; #1;

    // STR r4,[r5]: Rd is a source
    issue(32'hE585_4008, 32'h208);
    chk("str_is_load", 32'(id_is_load), 32'd0);
    chk("str_wb_en", 32'(id_wb_en), 32'd0);
    ex_valid = 1'b1; ex_rd = 4'd4; #1;
    chk("str_rd_src_haz", 32'(id_valid), 32'd0);
    ex_valid = 1'b0; #1;

    // CMP r3,r4
    issue(32'hE153_0004, 32'h20C);
    chk("cmp_wb_en", 32'(id_wb_en), 32'd0);
    chk("cmp_set_flags", 32'(id_set_flags), 32'd1);

    // ADD r0,r1,r2,LSL r3
    issue(32'hE081_0312, 32'h210);
    ex_valid = 1'b1; ex_rd = 4'd3; #1;
    chk("rs_haz", 32'(id_valid), 32'd0);
    chk("rs_addr3", 32'(rf_addr3), 32'd3);
    ex_valid = 1'b0; #1;

    // MOV r1,r2: Rn field not a source
    issue(32'hE1A0_1002, 32'h214);
    ex_valid = 1'b1; ex_rd = 4'd0; #1;
    chk("mov_rn_unused", 32'(id_valid), 32'd1);
    ex_rd = 4'd2; #1;
    chk("mov_rm_haz", 32'(id_valid), 32'd0);
    ex_valid = 1'b0; #1;

    issue(32'hEC00_0000, 32'h218);
    chk("undef_illegal", 32'(id_illegal), 32'd1);
    chk("undef_wb_en", 32'(id_wb_en), 32'd0);
    chk("undef_imm", id_imm, 32'd0);

    // Flush together with stall and an offered instruction
    flush = 1'b1; stall_in = 1'b1;
    fetch_bus.if_valid = 1'b1;
    fetch_bus.if_instr = 32'hE082_1003;
    fetch_bus.if_pc    = 32'h300;
    #1;
    chk("flush_id_valid_comb", 32'(id_valid), 32'd0);
    chk("flush_stall_ready", 32'(fetch_bus.if_ready), 32'd0);
    step();
    flush = 1'b0; stall_in = 1'b0; fetch_bus.if_valid = 1'b0; #1;
    chk("flush_id_valid", 32'(id_valid), 32'd0);
    chk("flush_nop_rd", 32'(rf_addr4), 32'd0);
    chk("flush_nop_rm", 32'(rf_addr2), 32'd0);
    chk("flush_if_ready", 32'(fetch_bus.if_ready), 32'd1);

    flush = 1'b1; fetch_bus.if_valid = 1'b1; #1;
    chk("flush_only_ready", 32'(fetch_bus.if_ready), 32'd1);
    step();
    flush = 1'b0; fetch_bus.if_valid = 1'b0; #1;
    chk("flush_discard_valid", 32'(id_valid), 32'd0);
    chk("flush_discard_rn", 32'(rf_addr1), 32'd0);

    // Continuous hazard drives the counter into saturation
    issue(32'hE082_1003, 32'h400);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 4'd2;
    repeat (13) step();
    chk("sat_count_14", 32'(stall_count), 32'd14);
    repeat (7) step();
    chk("sat_count_15", 32'(stall_count), 32'd15);
    chk("sat_held_rn", 32'(rf_addr1), 32'd2);
    chk("sat_id_valid", 32'(id_valid), 32'd0);

    rst = 1'b1;
    step();
    rst = 1'b0; #1;
    chk("midrst_count", 32'(stall_count), 32'd0);
    chk("midrst_valid", 32'(id_valid), 32'd0);
    chk("midrst_ready", 32'(fetch_bus.if_ready), 32'd1);
    chk("midrst_rn", 32'(rf_addr1), 32'd0);
    chk("midrst_pc", id_pc, 32'd0);
    ex_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
IF/ID pipeline register and instruction decoder that sits directly upstream of the register bank.
- Latches the fetched 32-bit ARM instruction and its PC.
- Drives the four register-bank read addresses and the decoded control fields for execute.
- Detects load-use hazards against the execute stage and inserts bubbles.
- Counts stall cycles for performance monitoring.

Parameters:
N, 32, data/PC width
CNT_W, 16, stall counter width (saturating)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-high reset
if_valid  in  1  fetch presents an instruction
if_instr  in  N  fetched instruction
if_pc  in  N  PC of fetched instruction
if_ready  out  1  stage accepts the instruction this cycle
flush  in  1  branch taken downstream; kill held instruction
stall_in  in  1  downstream cannot accept
ex_valid  in  1  execute stage holds a valid instruction
ex_is_load  in  1  that instruction is a load
ex_rd  in  4  its destination register
rf_addr1..rf_addr4  out  4 each  register-bank read addresses: Rn, Rm, Rs, Rd
id_valid  out  1  decoded instruction valid to execute
id_pc  out  N  held PC
id_cond  out  4  instr[31:28]
id_class  out  2  instr[27:26]: 00 data-proc, 01 load/store, 10 branch, 11 unsupported
id_imm_en  out  1  instr[25]
id_set_flags  out  1  instr[20] when class=00
id_is_load  out  1  class=01 and instr[20]
id_wb_en  out  1  writes Rd: data-proc except TST/TEQ/CMP/CMN (opcode 10xx), or load
id_rd  out  4  instr[15:12]
id_imm  out  N  class 00: zero-extended instr[7:0]; class 01: zero-extended instr[11:0]; class 10: sign-extended instr[23:0] shifted left 2
id_illegal  out  1  class=11
stall_count  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset:
  - valid_q=0 and instr_q=0xE1A00000 (MOV r0,r0 NOP).
  - pc_q=0, stall_count=0.
  - All outputs are derived from these values, so id_valid=0 and if_ready=1 out of reset (no hazard is possible while valid_q=0).
- Field positions:
  - Rn=[19:16], Rd=[15:12], Rs=[11:8], Rm=[3:0].
  - rf_addr1..4 are combinational from instr_q, so they are stable before the bank's negedge read in the same cycle.
- Operand use:
  - uses_rn: class 00 except MOV/MVN (opcode 1101/1111), and class 01.
  - uses_rm: class 00 or 01 with instr[25]=0 (register operand).
  - uses_rs: class 00 with instr[25]=0 and instr[4]=1.
  - uses_rd_src: class 01 store (instr[20]=0).
- Hazard is 1 when all of the following hold:
  - valid_q, ex_valid and ex_is_load are 1;
  - ex_rd equals a used source register.
- Hold and bubble:
  - hold = stall_in | hazard.
  - if_ready = ~hold.
  - id_valid = valid_q & ~hazard & ~flush.
- Register update priority, highest first:
  - (1) rst.
  - (2) flush: valid_q←0, instr_q←NOP; an incoming instruction in the same cycle is discarded and if_ready is still reported.
  - (3) hold: all registers retain their values.
  - (4) if_valid: capture instr/pc, valid_q←1.
  - (5) otherwise valid_q←0.
- A hazard lasts one cycle per load: the next cycle ex_valid is driven low by the bubble, so the hazard clears.
- stall_count:
  - Increments when hazard=1 and rst=0.
  - Saturates at all-ones.
  - Not incremented for stall_in-only holds.
- Reset asserted mid-hold or mid-flush wins unconditionally. The next cycle matches the post-reset state.
- Simultaneous stall_in and flush: flush wins.

Decomposition:
- Package decode_pkg holds:
  - class enum (CLS_DP, CLS_LS, CLS_BR, CLS_UNDEF);
  - field bit-position constants;
  - NOP constant;
  - data-proc opcode constants for TST/TEQ/CMP/CMN/MOV/MVN.
- One combinational sub-module, decode_fields: instr in; class, uses_* flags, wb_en, imm out.
- Hazard logic, pipeline register and counter stay in decode_stage.

Test Plan:
- Reset then idle -> id_valid=0, if_ready=1, rf_addr1..4=0, stall_count=0.
- ADD r1,r2,r3 (0xE0821003) with if_valid=1 -> next cycle:
  - id_valid=1; rf_addr1=2, rf_addr2=3, id_rd=1; id_wb_en=1, id_class=00.
- Branch 0xEAFFFFFE -> id_class=10, id_imm=0xFFFFFFF8, id_wb_en=0.
- Load-use: held ADD r1,r2,r3 with ex_valid=1, ex_is_load=1, ex_rd=3 -> one cycle with:
  - id_valid=0, if_ready=0, instruction retained, stall_count=1;
  - then ex_valid=0 -> id_valid=1.
- stall_in=1 for 3 cycles while a new instruction is offered -> the held instruction is unchanged, if_ready=0, stall_count unchanged.
- flush=1 together with stall_in=1 and if_valid=1 -> next cycle id_valid=0 and instr_q=NOP (rf_addr4=0).
